game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game FSM for the Tetris datapath. Drives the 3-bit state code consumed by
//  the falling-block row registers and the row file. Consumes their Stop/endgame
//  flags and the row-full flag. Sequences gravity ticks, one-shot key delivery,
//  block lock-down, bottom-up full-row clearing and new-block spawn.
// PARAMETERS
//  NUM_ROWS  20  playfield rows; row 0 is the top, NUM_ROWS-1 is the bottom
//  ROW_W     5   width of row_idx; must satisfy 2**ROW_W >= NUM_ROWS
//  FALL_DIV  25_000_000  clk cycles per gravity step; must be >= 2
// PORTS
//  clk            in   1      clock
//  reset          in   1      reset, asynchronous, active-high
//  start          in   1      start-game pulse; sampled only in IDLE
//  keycode        in   8      raw keyboard code; 0 = no key
//  stop           in   1      falling block collides on next move (combinational from row regs)
//  endgame        in   1      spawn collided (registered in row regs during ADD)
//  row_full       in   1      row at row_idx is completely filled
//  state          out  3      000 CHECK, 001 MOVE, 010 WRITE, 011 SHIFT, 100 ADD, 101 IDLE, 110 HALT, 111 INPUT
//  key_out        out  8      one-cycle key strobe to row regs; 0 otherwise
//  row_idx        out  ROW_W  row under check/shift
//  lines_cleared  out  16     saturating count of cleared rows
//  game_over      out  1      high in HALT
// BEHAVIOUR
//  Reset: state=IDLE, key_out=0, row_idx=0, lines_cleared=0, game_over=0, tick count=0, pending key cleared.
//  All outputs are registered. Every state except IDLE, INPUT, CHECK and HALT lasts exactly one cycle.
//  IDLE:  start=1 -> ADD. Otherwise hold.
//  ADD:   -> INPUT. Clear the tick counter.
//  INPUT: on the first cycle after ADD, endgame=1 -> HALT. This takes precedence over everything else.
//         The tick counter increments once per INPUT cycle. A tick occurs when count==FALL_DIV-1.
//         On a tick, clear the counter. Then stop=1 -> WRITE, else -> MOVE.
//  MOVE:  -> INPUT. The counter continues from 0.
//  WRITE: -> CHECK with row_idx=NUM_ROWS-1.
//  CHECK: row_full=1 -> SHIFT, and increment lines_cleared (saturate at 16'hFFFF).
//         row_full=0 and row_idx!=0 -> decrement row_idx and stay in CHECK.
//         row_full=0 and row_idx==0 -> ADD.
//  SHIFT: the row file collapses rows 0..row_idx down by one in this cycle.
//         Next state is CHECK with row_idx unchanged, so the same index is rechecked
//         (this handles stacked full rows).
//  HALT:  sticky until reset. game_over=1. start and keycode are ignored.
//  Key event: keycode!=0 and keycode!=the keycode registered last cycle. This is edge
//    detection, so a held key fires once. A release followed by a repress fires again.
//    - The event is latched into a one-deep pending register. A newer event overwrites it.
//    - key_out=pending for exactly one INPUT cycle with no tick, then pending clears.
//    - key_out=0 in all other states.
//  Simultaneous tick and key event: the tick wins. The key stays pending and is delivered on the next INPUT cycle.
//  Events arriving outside INPUT stay pending until INPUT is reached. Pending is discarded on entry to HALT.
//  reset mid-sequence (any state) -> reset values immediately (asynchronous). No partial clear is resumed.
// CONFIGURATION
//  SOFT_DROP_EN defined:
//    - While keycode==8'h16 is held in INPUT, the tick threshold is max(FALL_DIV/8,1)-1.
//    - 8'h16 never appears on key_out.
//    - If the counter is already >= the threshold when the key is pressed, a tick fires on the next INPUT cycle.
//  SOFT_DROP_EN undefined: 8'h16 is an ordinary key. It appears on key_out once per press (the row registers ignore it).
// TESTING (FALL_DIV=4, NUM_ROWS=20)
//  1 reset, start=1 one cycle -> state 101, 100, 111 on consecutive cycles. All counters 0.
//  2 stop=0, endgame=0, no keys -> 4 cycles of 111, 1 cycle of 001, repeating. key_out stays 0.
//  3 keycode=8'h07 held 10 cycles in INPUT -> key_out=8'h07 for exactly 1 cycle. Release and repress -> a second strobe.
//  4 stop=1 at a tick; row_full=1 only at row 19 on the first check -> 010, 011 (row_idx 19), lines_cleared=1,
//    then 000 at row 19, 18..0 (20 cycles), then 100.
//  5 endgame=1 on the first INPUT cycle after ADD -> 110 next cycle, game_over=1. start and keys are ignored until reset.
//  6 key event on the same cycle as a tick -> 001, then key_out=code on the first following INPUT cycle.
//    Under SOFT_DROP_EN, holding 8'h16 gives 1 cycle of INPUT per MOVE.

Source files
------------

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Top-level game FSM for the Tetris datapath. Produces the 3-bit state code
//   consumed by the falling-block row registers and the row file. It sequences
//   gravity ticks, one-shot key delivery, block lock-down, bottom-up full-row
//   clearing and new-block spawn.
//
//   Optional feature macro: SOFT_DROP_EN
//     defined   : holding key 8'h16 in INPUT shortens the gravity period to
//                 max(FALL_DIV/8,1) cycles, and 8'h16 is never sent on key_out.
//     undefined : 8'h16 is an ordinary key.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high reset
//   i_start          start-game pulse, only looked at in IDLE
//   i_keycode[7:0]   raw keyboard code, 0 = no key
//   i_stop           falling block would collide on its next move
//   i_endgame        spawned block collided (valid on first INPUT after ADD)
//   i_row_full       row at o_row_idx is completely filled
//   o_state[2:0]     000 CHECK, 001 MOVE, 010 WRITE, 011 SHIFT,
//                    100 ADD, 101 IDLE, 110 HALT, 111 INPUT
//   o_key_out[7:0]   one-cycle key strobe (only ever non-zero in INPUT)
//   o_row_idx        row under check/shift
//   o_lines_cleared  saturating count of cleared rows
//   o_game_over      high in HALT
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int NUM_ROWS = 20,
  parameter int ROW_W    = 5,
  parameter int FALL_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [7:0]       i_keycode,
  input  logic             i_stop,
  input  logic             i_endgame,
  input  logic             i_row_full,
  output logic [2:0]       o_state,
  output logic [7:0]       o_key_out,
  output logic [ROW_W-1:0] o_row_idx,
  output logic [15:0]      o_lines_cleared,
  output logic             o_game_over
);

  localparam int CNT_W = $clog2(FALL_DIV);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(FALL_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_CHECK = 3'b000,
    S_MOVE  = 3'b001,
    S_WRITE = 3'b010,
    S_SHIFT = 3'b011,
    S_ADD   = 3'b100,
    S_IDLE  = 3'b101,
    S_HALT  = 3'b110,
    S_INPUT = 3'b111
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic             r_first,     w_first_nxt;
  logic [7:0]       r_key_prev;
  logic             r_pend_vld,  w_pend_vld_nxt;
  logic [7:0]       r_pend_code, w_pend_code_nxt;
  logic [7:0]       r_key_out,   w_key_out_nxt;
  logic [ROW_W-1:0] r_row_idx,   w_row_idx_nxt;
  logic [15:0]      r_lines,     w_lines_nxt;
  logic             r_game_over, w_game_over_nxt;

  logic [CNT_W-1:0] w_thresh;
  logic             w_key_evt;
  logic             w_tick;

`ifdef SOFT_DROP_EN
  localparam int SD_DIV = ((FALL_DIV / 8) > 1) ? (FALL_DIV / 8) : 1;
  localparam logic [CNT_W-1:0] SD_MAX = CNT_W'(SD_DIV - 1);
  localparam logic [7:0] KEY_SOFT = 8'h16;
  logic w_soft;
  assign w_soft    = (r_state == S_INPUT) && (i_keycode == KEY_SOFT);
  // >= rather than == so a counter already past the short threshold ticks at once
  assign w_thresh  = w_soft ? SD_MAX : TICK_MAX;
  assign w_key_evt = (i_keycode != 8'h00) && (i_keycode != r_key_prev) &&
                     (i_keycode != KEY_SOFT);
`else
  assign w_thresh  = TICK_MAX;
  assign w_key_evt = (i_keycode != 8'h00) && (i_keycode != r_key_prev);
`endif

  assign w_tick = (r_state == S_INPUT) && (r_cnt >= w_thresh);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_first_nxt     = (r_state == S_ADD);
    w_key_out_nxt   = 8'h00;
    w_row_idx_nxt   = r_row_idx;
    w_lines_nxt     = r_lines;
    w_game_over_nxt = r_game_over;
    // newest key event always replaces whatever is pending
    w_pend_vld_nxt  = r_pend_vld | w_key_evt;
    w_pend_code_nxt = w_key_evt ? i_keycode : r_pend_code;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_INPUT;
      end
      S_INPUT: begin
        if (r_first && i_endgame) begin
          w_state_nxt     = S_HALT;
          w_game_over_nxt = 1'b1;
          w_pend_vld_nxt  = 1'b0;
        end else if (w_tick) begin
          // tick wins over key delivery; the key stays pending
          w_cnt_nxt   = '0;
          w_state_nxt = i_stop ? S_WRITE : S_MOVE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          // no tick means we stay in INPUT, so the strobe lands in INPUT
          if (w_key_evt || r_pend_vld) begin
            w_key_out_nxt  = w_pend_code_nxt;
            w_pend_vld_nxt = 1'b0;
          end
        end
      end
      S_MOVE: begin
        w_state_nxt = S_INPUT;
      end
      S_WRITE: begin
        w_row_idx_nxt = ROW_LAST;
        w_state_nxt   = S_CHECK;
      end
      S_CHECK: begin
        if (i_row_full) begin
          w_state_nxt = S_SHIFT;
          if (r_lines != 16'hFFFF) w_lines_nxt = r_lines + 16'd1;
        end else if (r_row_idx != '0) begin
          w_row_idx_nxt = r_row_idx - 1'b1;
        end else begin
          w_state_nxt = S_ADD;
        end
      end
      S_SHIFT: begin
        // same index is rechecked: the row above has dropped into it
        w_state_nxt = S_CHECK;
      end
      S_HALT: begin
        w_game_over_nxt = 1'b1;
        w_pend_vld_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_first     <= 1'b0;
      r_key_prev  <= 8'h00;
      r_pend_vld  <= 1'b0;
      r_pend_code <= 8'h00;
      r_key_out   <= 8'h00;
      r_row_idx   <= '0;
      r_lines     <= 16'd0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_first     <= w_first_nxt;
      r_key_prev  <= i_keycode;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_code <= w_pend_code_nxt;
      r_key_out   <= w_key_out_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_lines     <= w_lines_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign o_state         = r_state;
  assign o_key_out       = r_key_out;
  assign o_row_idx       = r_row_idx;
  assign o_lines_cleared = r_lines;
  assign o_game_over     = r_game_over;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer (FALL_DIV=4, NUM_ROWS=20, default build).
// Expected state runs (state, length, row_idx and lines at run start) and
// expected key strobes are queued by the stimulus; a monitor pops and compares.
module tb_game_sequencer;

  localparam int ST_CHECK = 0;
  localparam int ST_MOVE  = 1;
  localparam int ST_WRITE = 2;
  localparam int ST_SHIFT = 3;
  localparam int ST_ADD   = 4;
  localparam int ST_IDLE  = 5;
  localparam int ST_HALT  = 6;
  localparam int ST_INPUT = 7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  keycode;
  logic        stop;
  logic        endgame;
  logic        row_full;
  logic [2:0]  state;
  logic [7:0]  key_out;
  logic [4:0]  row_idx;
  logic [15:0] lines_cleared;
  logic        game_over;

  logic [31:0] full_mask;

  game_sequencer #(.NUM_ROWS(20), .ROW_W(5), .FALL_DIV(4)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_keycode(keycode),
    .i_stop(stop), .i_endgame(endgame), .i_row_full(row_full),
    .o_state(state), .o_key_out(key_out), .o_row_idx(row_idx),
    .o_lines_cleared(lines_cleared), .o_game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign row_full = full_mask[row_idx];

  // Row-file model: SHIFT at row r moves rows 0..r-1 down one, row 0 empties.
  always @(negedge clk) begin
    if (state == 3'd3) begin
      for (int i = 31; i >= 1; i--)
        if (i <= int'(row_idx)) full_mask[i] = full_mask[i-1];
      full_mask[0] = 1'b0;
    end
  end

  typedef struct {
    int st;
    int len;
    int row;
    int lines;
  } run_t;

  run_t       exp_run[$];
  logic [7:0] exp_key[$];

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_run(input int st, input int len, input int row, input int lines);
    run_t r;
    r.st = st; r.len = len; r.row = row; r.lines = lines;
    exp_run.push_back(r);
  endtask

  // Monitor: run-length tracker on o_state plus key strobe checker.
  bit   have_run = 1'b0;
  int   run_st, run_len, run_row, run_lines;
  run_t e;
  logic [7:0] kexp;

  always @(posedge clk) begin
    #1;
    if (!mon_en) begin
      have_run = 1'b0;
    end else begin
      if (key_out != 8'h00) begin
        if (exp_key.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL key_unexpected: got %02h expected none", key_out);
        end else begin
          kexp = exp_key.pop_front();
          check("key_out", {24'h0, key_out}, {24'h0, kexp});
        end
        check("key_state", {29'h0, state}, ST_INPUT);
      end
      if (have_run && int'(state) == run_st) begin
        run_len++;
      end else begin
        if (have_run) begin
          n_cmp++;
          if (exp_run.size() == 0) begin
            n_fail++;
            $display("FAIL run_unexpected: got st=%0d len=%0d expected none", run_st, run_len);
          end else begin
            e = exp_run.pop_front();
            if (e.st != run_st || (e.len >= 0 && e.len != run_len) ||
                (e.row >= 0 && e.row != run_row) || (e.lines >= 0 && e.lines != run_lines)) begin
              n_fail++;
              $display("FAIL run: got st=%0d len=%0d row=%0d lines=%0d expected st=%0d len=%0d row=%0d lines=%0d",
                       run_st, run_len, run_row, run_lines, e.st, e.len, e.row, e.lines);
            end
          end
        end
        have_run  = 1'b1;
        run_st    = int'(state);
        run_len   = 1;
        run_row   = int'(row_idx);
        run_lines = int'(lines_cleared);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, {29'h0, state}, ST_IDLE);
    check({tag, "_key_out"}, {24'h0, key_out}, 0);
    check({tag, "_row_idx"}, {27'h0, row_idx}, 0);
    check({tag, "_lines"}, {16'h0, lines_cleared}, 0);
    check({tag, "_game_over"}, {31'h0, game_over}, 0);
  endtask

  task automatic do_reset(input string tag);
    mon_en  = 1'b0;
    start   = 1'b0;
    keycode = 8'h00;
    stop    = 1'b0;
    endgame = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int i = 0;
    while ((exp_run.size() != 0 || exp_key.size() != 0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drained"}, exp_run.size() + exp_key.size(), 0);
    exp_run.delete();
    exp_key.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    keycode   = 8'h00;
    stop      = 1'b0;
    endgame   = 1'b0;
    full_mask = 32'h0;

    // A: start, free fall, held/released/re-pressed keys, 8'h16 as ordinary key
    do_reset("rstA");
    push_run(ST_IDLE, -1, 0, 0);
    push_run(ST_ADD, 1, 0, 0);
    for (int k = 0; k < 8; k++) begin
      push_run(ST_INPUT, 4, -1, 0);
      push_run(ST_MOVE, 1, -1, 0);
    end
    exp_key.push_back(8'h07);
    exp_key.push_back(8'h07);
    exp_key.push_back(8'h1D);
    exp_key.push_back(8'h16);
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(3); keycode = 8'h07;
    cyc(10); keycode = 8'h00;
    cyc(3); keycode = 8'h07;
    cyc(4); keycode = 8'h1D;
    cyc(3); keycode = 8'h00;
    cyc(3); keycode = 8'h16;
    cyc(1); keycode = 8'h00;
    drain("A", 100);

    // C1: lock-down, single full bottom row, keys pressed during CHECK (newest wins)
    do_reset("rstC1");
    full_mask = 32'h0008_0000;
    stop = 1'b1;
    push_run(ST_IDLE, -1, 0, 0);
    push_run(ST_ADD, 1, 0, 0);
    push_run(ST_INPUT, 4, -1, 0);
    push_run(ST_WRITE, 1, 0, 0);
    push_run(ST_CHECK, 1, 19, 0);
    push_run(ST_SHIFT, 1, 19, 1);
    push_run(ST_CHECK, 20, 19, 1);
    push_run(ST_ADD, 1, 0, 1);
    exp_key.push_back(8'h22);
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(9); keycode = 8'h11;
    cyc(1); keycode = 8'h00;
    cyc(3); keycode = 8'h22;
    cyc(1); keycode = 8'h00;
    drain("C1", 100);

    // C2: stacked full rows 19,18 and a separate full row 5
    do_reset("rstC2");
    full_mask = 32'h000C_0020;
    stop = 1'b1;
    push_run(ST_IDLE, -1, 0, 0);
    push_run(ST_ADD, 1, 0, 0);
    push_run(ST_INPUT, 4, -1, 0);
    push_run(ST_WRITE, 1, 0, 0);
    push_run(ST_CHECK, 1, 19, 0);
    push_run(ST_SHIFT, 1, 19, 1);
    push_run(ST_CHECK, 1, 19, 1);
    push_run(ST_SHIFT, 1, 19, 2);
    push_run(ST_CHECK, 13, 19, 2);
    push_run(ST_SHIFT, 1, 7, 3);
    push_run(ST_CHECK, 8, 7, 3);
    push_run(ST_ADD, 1, 0, 3);
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    drain("C2", 100);

    // F: endgame outside first INPUT is ignored; key on the tick cycle is deferred
    do_reset("rstF");
    push_run(ST_IDLE, -1, 0, 0);
    push_run(ST_ADD, 1, 0, 0);
    push_run(ST_INPUT, 4, -1, 0);
    push_run(ST_MOVE, 1, -1, 0);
    push_run(ST_INPUT, 4, -1, 0);
    push_run(ST_MOVE, 1, -1, 0);
    exp_key.push_back(8'h2A);
    cyc(1); start = 1'b1;
    cyc(1); start = 1'b0;
    cyc(2); endgame = 1'b1;
    cyc(2); endgame = 1'b0; keycode = 8'h2A;
    cyc(3); keycode = 8'h00;
    drain("F", 60);

    // D: endgame on first INPUT after ADD -> sticky HALT, then async reset
    do_reset("rstD");
    push_run(ST_IDLE, -1, 0, 0);
    push_run(ST_ADD, 1, 0, 0);
    push_run(ST_INPUT, 1, 0, 0);
    cyc(1); start = 1'b1; keycode = 8'h33; endgame = 1'b1;
    cyc(1); start = 1'b0; keycode = 8'h00;
    drain("D", 20);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      start   = k[0];
      keycode = (k % 3 == 0) ? 8'h00 : (8'h40 + 8'(k));
    end
    cyc(1);
    check("halt_state", {29'h0, state}, ST_HALT);
    check("halt_game_over", {31'h0, game_over}, 1);
    check("halt_key_out", {24'h0, key_out}, 0);
    check("halt_lines", {16'h0, lines_cleared}, 0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check_reset_vals("async");
    do_reset("rstEnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
